trans_conv_input_pacer: RTL

TRANS_CONV_INPUT_PACER -- requirements
Module: trans_conv_input_pacer

---
 rtl/trans_conv_input_pacer_pkg.sv | 34 +++
 rtl/trans_conv_input_pacer_if.sv | 35 +++
 rtl/trans_conv_input_pacer_sync_fifo.sv | 77 +++++++
 rtl/trans_conv_input_pacer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/trans_conv_input_pacer_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the input pacer.
package trans_conv_input_pacer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IN_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_PIX_GAP    = 4;
  localparam int DEF_ROW_GAP    = 20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_PIX_WAIT = 2'd2,
    ST_ROW_WAIT = 2'd3
  } pacer_state_e;

  // Width of a row/column index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counter must be able to represent a completely full FIFO.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Gap counter must hold the larger of the two gap loads.
  function automatic int gap_width(input int pix_gap, input int row_gap);
    int mx;
    mx = (pix_gap > row_gap) ? pix_gap : row_gap;
    return (mx > 0) ? $clog2(mx + 1) : 1;
  endfunction

endpackage

// File: rtl/trans_conv_input_pacer_if.sv
// Upstream word stream plus paced pixel stream toward the transposed-conv layer.
interface trans_conv_input_pacer_if
  import trans_conv_input_pacer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int IDX_W = idx_width(IN_WIDTH);
  localparam int CNT_W = count_width(FIFO_DEPTH);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [IDX_W-1:0]      row_idx;
  logic [IDX_W-1:0]      col_idx;
  logic                  frame_done;
  logic [CNT_W-1:0]      fifo_count;

  // The pacer itself.
  modport slave (
    input  valid_in, data_in,
    output ready_in, valid_out, data_out, row_idx, col_idx, frame_done, fifo_count
  );

  // Whoever feeds words in and watches pixels come out.
  modport master (
    output valid_in, data_in,
    input  ready_in, valid_out, data_out, row_idx, col_idx, frame_done, fifo_count
  );

endinterface

// File: rtl/trans_conv_input_pacer_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and occupancy count.
module sync_fifo
  import trans_conv_input_pacer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear_i,
  input  logic                               push_i,
  input  logic                               pop_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic [count_width(FIFO_DEPTH)-1:0] count_o,
  output logic                               full_o,
  output logic                               empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = count_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer/occupancy; depth is a power of two so pointers wrap on their own.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptiness is tracked by count_q, so stale words are never read.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trans_conv_input_pacer.sv
// Paces buffered pixels into single-cycle pulses with per-pixel and per-row idle gaps.
module trans_conv_input_pacer
  import trans_conv_input_pacer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PIX_GAP    = DEF_PIX_GAP,
  parameter int ROW_GAP    = DEF_ROW_GAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  trans_conv_input_pacer_if.slave  bus
);

  localparam int IDX_W = idx_width(IN_WIDTH);
  localparam int CNT_W = count_width(FIFO_DEPTH);
  localparam int GAP_W = gap_width(PIX_GAP, ROW_GAP);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_WIDTH - 1);
  localparam logic [GAP_W-1:0] PIX_LOAD = GAP_W'(PIX_GAP);
  localparam logic [GAP_W-1:0] ROW_LOAD = GAP_W'(ROW_GAP);

  pacer_state_e          state_q;
  logic                  valid_out_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [IDX_W-1:0]      row_idx_q, col_idx_q;
  logic                  frame_done_q;
  logic [IDX_W-1:0]      next_row_q, next_col_q;
  logic [GAP_W-1:0]      gap_cnt_q;

  logic [DATA_WIDTH-1:0] fifo_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, pop_slot, gap_done, next_is_last;

  assign bus.ready_in = !fifo_full && !clear && !rst;
  assign push         = bus.valid_in && bus.ready_in;
  assign gap_done     = (gap_cnt_q <= GAP_W'(1));
  assign pop          = pop_slot && !fifo_empty && !clear;
  assign next_is_last = (next_row_q == LAST_IDX) && (next_col_q == LAST_IDX);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.data_in),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A pop slot is open in IDLE and on the last cycle of a gap; popping straight out of the
  // final gap cycle keeps back-to-back pulses exactly PIX_GAP/ROW_GAP idle cycles apart.
  always_comb begin
    pop_slot = 1'b0;
    case (state_q)
      ST_IDLE:                  pop_slot = 1'b1;
      ST_PIX_WAIT, ST_ROW_WAIT: pop_slot = gap_done;
      default:                  pop_slot = 1'b0;
    endcase
  end

  // Pacing FSM with registered pulse, pixel, position and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      frame_done_q <= 1'b0;
      next_row_q   <= '0;
      next_col_q   <= '0;
      gap_cnt_q    <= '0;
    end else if (clear) begin
      state_q      <= ST_IDLE;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      frame_done_q <= 1'b0;
      next_row_q   <= '0;
      next_col_q   <= '0;
      gap_cnt_q    <= '0;
    end else if (pop) begin
      state_q      <= ST_EMIT;
      valid_out_q  <= 1'b1;
      data_out_q   <= fifo_data;
      row_idx_q    <= next_row_q;
      col_idx_q    <= next_col_q;
      frame_done_q <= next_is_last;
      gap_cnt_q    <= '0;
      if (next_col_q == LAST_IDX) begin
        next_col_q <= '0;
        next_row_q <= (next_row_q == LAST_IDX) ? '0 : next_row_q + IDX_W'(1);
      end else begin
        next_col_q <= next_col_q + IDX_W'(1);
      end
    end else begin
      case (state_q)
        ST_EMIT: begin
          valid_out_q  <= 1'b0;
          frame_done_q <= 1'b0;
          if (col_idx_q == LAST_IDX) begin
            state_q   <= ST_ROW_WAIT;
            gap_cnt_q <= ROW_LOAD;
          end else begin
            state_q   <= ST_PIX_WAIT;
            gap_cnt_q <= PIX_LOAD;
          end
        end
        ST_PIX_WAIT, ST_ROW_WAIT: begin
          if (gap_done) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        ST_IDLE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.valid_out  = valid_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.col_idx    = col_idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.fifo_count = fifo_count;

endmodule
